frog_stream_checker: RTL and testbench

//  Receive-side partner of frog_chip: samples the serial LFSR bit stream ('out' of frog_chip), self-synchronises
//  to it and flags every bit that breaks the programmed recurrence. Loaded with the same serial tap program as
//  the generator; seed not needed. Sits on the link sink as a BER monitor / link self-test.

---
 rtl/frog_stream_checker_pkg.sv | 16 +
 rtl/frog_stream_checker_if.sv | 29 ++
 rtl/frog_sat_counter.sv | 23 ++
 rtl/frog_stream_checker.sv | 147 ++++++++++++++
 tb/tb_frog_stream_checker.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/frog_stream_checker_pkg.sv
// Shared definitions for the frog stream checker: state encodings and default sizing.
package frog_stream_checker_pkg;

    // Checker states. The encodings are shared with the rest of the frog link.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_LOCKED = 2'd2
    } frog_state_t;

    // Default LFSR length, shared with the generator side.
    localparam int FROG_N_DEFAULT          = 8;
    localparam int FROG_CNT_W_DEFAULT      = 16;
    localparam int FROG_LOSS_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/frog_stream_checker_if.sv
// Stream-side bundle of the checker: tap program load, received stream and status/counter outputs.
// The serial tap bit is named prog because 'program' is a reserved word.
interface frog_stream_checker_if
    import frog_stream_checker_pkg::*;
#(
    parameter int CNT_W = FROG_CNT_W_DEFAULT
);
    logic             load;       // tap program shift enable
    logic             prog;       // serial tap bit, LSB first
    logic             enable;     // 'in' valid this cycle
    logic             in;         // received stream bit
    logic             locked;     // checker synchronised
    logic             err;        // previous checked bit mismatched
    logic             sync_loss;  // LOCKED -> FILL after too many consecutive mismatches
    logic [CNT_W-1:0] err_count;  // saturating mismatch count
    logic [CNT_W-1:0] bit_count;  // saturating checked-bit count

    // Source side: drives the program and stream, observes status.
    modport master (
        output load, prog, enable, in,
        input  locked, err, sync_loss, err_count, bit_count
    );

    // Checker side.
    modport slave (
        input  load, prog, enable, in,
        output locked, err, sync_loss, err_count, bit_count
    );
endinterface

// File: rtl/frog_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module frog_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_reg;

    // Count up on inc, stop at the maximum value, clear on reset or clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q_reg <= '0;
        end else if (inc && (q_reg != '1)) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/frog_stream_checker.sv
// Receive-side LFSR stream checker. Shifts every received bit into a history register,
// predicts each bit from the programmed taps, and once N bits have been collected flags
// every bit that breaks the recurrence. A run of LOSS_LIMIT consecutive mismatches drops
// the checker back to FILL so it can resynchronise on the incoming stream.
module frog_stream_checker
    import frog_stream_checker_pkg::*;
#(
    parameter int N          = FROG_N_DEFAULT,
    parameter int CNT_W      = FROG_CNT_W_DEFAULT,
    parameter int LOSS_LIMIT = FROG_LOSS_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    frog_stream_checker_if.slave  bus
);
    localparam int RUN_W  = $clog2(LOSS_LIMIT + 1);
    localparam int FILL_W = $clog2(N + 1);

    // Last values before the terminal count; comparing against these avoids a wider adder.
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOSS_LIMIT - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

    frog_state_t       state_reg;
    logic [N-1:0]      taps_reg;
    logic [N-1:0]      hist_reg;
    logic [FILL_W-1:0] fill_cnt_reg;
    logic [RUN_W-1:0]  run_cnt_reg;
    logic              load_d_reg;
    logic              locked_reg;
    logic              err_reg;
    logic              sync_loss_reg;

    logic [N-1:0]      tap_hits;
    logic              predict;
    logic              load_fall;
    logic              bit_valid;
    logic              check_bit;
    logic              mismatch;
    logic              run_hit;
    logic [CNT_W-1:0]  err_count_q;
    logic [CNT_W-1:0]  bit_count_q;

    // Per-tap contributions; taps[i] pairs with hist[i] (hist[0] is the newest bit).
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_tap
            assign tap_hits[gi] = taps_reg[gi] & hist_reg[gi];
        end
    endgenerate

    assign predict   = ^tap_hits;

    // The first cycle after load drops is spent choosing FILL or IDLE, so no bit is taken then.
    assign load_fall = !bus.load && load_d_reg;
    assign bit_valid = bus.enable && !bus.load && !load_fall && (state_reg != ST_IDLE);
    assign check_bit = bit_valid && (state_reg == ST_LOCKED);
    assign mismatch  = check_bit && (bus.in != predict);
    assign run_hit   = mismatch && (run_cnt_reg == RUN_LAST);

    // Mismatch counter; still counts the mismatch that triggers sync loss.
    frog_sat_counter #(.W(CNT_W)) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.load),
        .inc   (mismatch),
        .q     (err_count_q)
    );

    // Checked-bit counter; only bits seen while LOCKED are counted.
    frog_sat_counter #(.W(CNT_W)) u_bit_count (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.load),
        .inc   (check_bit),
        .q     (bit_count_q)
    );

    // Tap loading, history shifting and the IDLE/FILL/LOCKED state machine with registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            taps_reg      <= '0;
            hist_reg      <= '0;
            fill_cnt_reg  <= '0;
            run_cnt_reg   <= '0;
            load_d_reg    <= 1'b0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
            sync_loss_reg <= 1'b0;
        end else if (bus.load) begin
            // Serial program, LSB first: after N cycles bit i sits in taps[i].
            taps_reg      <= {bus.prog, taps_reg[N-1:1]};
            state_reg     <= ST_IDLE;
            hist_reg      <= '0;
            fill_cnt_reg  <= '0;
            run_cnt_reg   <= '0;
            load_d_reg    <= 1'b1;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
            sync_loss_reg <= 1'b0;
        end else begin
            load_d_reg    <= 1'b0;
            err_reg       <= 1'b0;
            sync_loss_reg <= 1'b0;
            if (load_fall) begin
                // An all-zero program has no recurrence to check.
                state_reg <= (taps_reg != '0) ? ST_FILL : ST_IDLE;
            end else if (bit_valid) begin
                // Self-synchronising: the received bit enters history, never the prediction.
                hist_reg <= {hist_reg[N-2:0], bus.in};
                case (state_reg)
                    ST_FILL: begin
                        if (fill_cnt_reg == FILL_LAST) begin
                            state_reg    <= ST_LOCKED;
                            locked_reg   <= 1'b1;
                            fill_cnt_reg <= '0;
                        end else begin
                            fill_cnt_reg <= fill_cnt_reg + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (mismatch) begin
                            err_reg <= 1'b1;
                            if (run_hit) begin
                                sync_loss_reg <= 1'b1;
                                locked_reg    <= 1'b0;
                                fill_cnt_reg  <= '0;
                                run_cnt_reg   <= '0;
                                state_reg     <= ST_FILL;
                            end else begin
                                run_cnt_reg <= run_cnt_reg + 1'b1;
                            end
                        end else begin
                            run_cnt_reg <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.locked    = locked_reg;
    assign bus.err       = err_reg;
    assign bus.sync_loss = sync_loss_reg;
    assign bus.err_count = err_count_q;
    assign bus.bit_count = bit_count_q;
endmodule

// File: tb/tb_frog_stream_checker.sv
// Directed bench: an in-bench LFSR source (taps 8'b10111000, seed 8'b10101010) feeds the
// checker; a second checker with 4-bit counters follows the same stimulus for saturation.
module tb_frog_stream_checker;
    localparam int         N    = 8;
    localparam logic [7:0] TAPS = 8'b10111000;
    localparam logic [7:0] SEED = 8'b10101010;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frog_stream_checker_if #(.CNT_W(16)) bus  ();
    frog_stream_checker_if #(.CNT_W(4))  bus4 ();

    assign bus4.load   = bus.load;
    assign bus4.prog   = bus.prog;
    assign bus4.enable = bus.enable;
    assign bus4.in     = bus.in;

    frog_stream_checker #(.N(N), .CNT_W(16), .LOSS_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    frog_stream_checker #(.N(N), .CNT_W(4), .LOSS_LIMIT(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        logic rst, load, prog, enable, in;
        logic exp_locked, exp_err, exp_sync;
        int   exp_errc, exp_bitc;
    } vec_t;

    vec_t       vecs [14];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] gen_reg;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("[%0t] %s = %0d ok", $time, name, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next source bit from the reference recurrence (gen_reg[0] is the newest bit).
    task automatic next_bit(output logic b);
        b = ^(gen_reg & TAPS);
        gen_reg = {gen_reg[6:0], b};
    endtask

    // One enabled stream bit, optionally inverted on the wire.
    task automatic send(input logic inv);
        logic b;
        next_bit(b);
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        bus.in     = b ^ inv;
        tick();
    endtask

    function automatic vec_t mk(input logic r, l, p, e, i);
        vec_t v;
        v.rst = r; v.load = l; v.prog = p; v.enable = e; v.in = i;
        v.exp_locked = 1'b0; v.exp_err = 1'b0; v.exp_sync = 1'b0;
        v.exp_errc = 0; v.exp_bitc = 0;
        return v;
    endfunction

    initial begin
        logic seen;
        logic [7:0] taps_v;
        taps_v = TAPS;

        // Reset, IDLE enable toggling, then the serial tap program: all outputs stay 0.
        vecs[0] = mk(1, 0, 0, 1, 1);
        vecs[1] = mk(1, 0, 0, 0, 0);
        vecs[2] = mk(0, 0, 0, 1, 1);
        vecs[3] = mk(0, 0, 0, 0, 0);
        vecs[4] = mk(0, 0, 0, 1, 0);
        vecs[5] = mk(0, 0, 0, 1, 1);
        for (int i = 0; i < N; i++) vecs[6 + i] = mk(0, 1, taps_v[i], 1, 1);

        rst = 1'b1; bus.load = 1'b0; bus.prog = 1'b0; bus.enable = 1'b0; bus.in = 1'b0;
        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst; bus.load = vecs[i].load; bus.prog = vecs[i].prog;
            bus.enable = vecs[i].enable; bus.in = vecs[i].in;
            tick();
            check($sformatf("vec%0d locked", i), bus.locked, vecs[i].exp_locked);
            check($sformatf("vec%0d err", i), bus.err, vecs[i].exp_err);
            check($sformatf("vec%0d sync_loss", i), bus.sync_loss, vecs[i].exp_sync);
            check($sformatf("vec%0d err_count", i), bus.err_count, vecs[i].exp_errc);
            check($sformatf("vec%0d bit_count", i), bus.bit_count, vecs[i].exp_bitc);
        end

        // Lock: first post-load bit is ignored, locked visible after the 9th bit.
        gen_reg = SEED;
        for (int i = 0; i < 8; i++) send(1'b0);
        check("lock not yet after 8 bits", bus.locked, 0);
        send(1'b0);
        check("locked after 9 bits", bus.locked, 1);
        check("bit_count at lock", bus.bit_count, 0);

        // 255 clean bits.
        seen = 1'b0;
        for (int i = 0; i < 255; i++) begin
            send(1'b0);
            seen = seen | bus.err | bus.sync_loss;
        end
        check("clean run err seen", seen, 0);
        check("clean run bit_count", bus.bit_count, 255);
        check("clean run err_count", bus.err_count, 0);
        check("cnt4 bit_count saturated", bus4.bit_count, 15);

        // Single inverted bit: taps 3,4,5,7 re-hit it 4,5,6,8 bits later.
        send(1'b1);
        check("flip err", bus.err, 1);
        check("flip err_count", bus.err_count, 1);
        for (int k = 1; k <= 12; k++) begin
            send(1'b0);
            check($sformatf("flip+%0d err", k), bus.err,
                  (k == 4 || k == 5 || k == 6 || k == 8) ? 1 : 0);
            check($sformatf("flip+%0d sync_loss", k), bus.sync_loss, 0);
        end
        check("flip locked", bus.locked, 1);
        check("flip err_count", bus.err_count, 5);
        check("flip bit_count", bus.bit_count, 268);

        // Four inverted bits: sync loss on the 4th.
        for (int k = 1; k <= 4; k++) begin
            send(1'b1);
            check($sformatf("inv%0d err", k), bus.err, 1);
            check($sformatf("inv%0d sync_loss", k), bus.sync_loss, (k == 4) ? 1 : 0);
        end
        check("loss locked", bus.locked, 0);
        check("loss err_count", bus.err_count, 9);
        check("loss bit_count", bus.bit_count, 272);
        send(1'b0);
        check("sync_loss one cycle", bus.sync_loss, 0);
        for (int i = 0; i < 6; i++) send(1'b0);
        check("relock not yet after 7", bus.locked, 0);
        send(1'b0);
        check("relock after 8", bus.locked, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(1'b0);
            seen = seen | bus.err;
        end
        check("relock err seen", seen, 0);
        check("relock err_count", bus.err_count, 9);
        check("relock bit_count", bus.bit_count, 282);

        // enable low 20 cycles with garbage on in.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.enable = 1'b0;
            bus.in = 1'($urandom_range(0, 1));
            tick();
            seen = seen | bus.err | bus.sync_loss;
        end
        check("pause err seen", seen, 0);
        check("pause bit_count", bus.bit_count, 282);
        check("pause locked", bus.locked, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(1'b0);
            seen = seen | bus.err;
        end
        check("resume err seen", seen, 0);
        check("resume err_count", bus.err_count, 9);
        check("resume bit_count", bus.bit_count, 302);

        // Saturation of the 4-bit err_count, err still pulsing.
        for (int k = 0; k < 4; k++) send(1'b1);
        check("sat loss1 err_count", bus.err_count, 13);
        check("sat loss1 cnt4 err_count", bus4.err_count, 13);
        for (int i = 0; i < 8; i++) send(1'b0);
        check("sat relock", bus.locked, 1);
        for (int k = 1; k <= 4; k++) begin
            send(1'b1);
            if (k >= 3) check($sformatf("sat inv%0d cnt4 err", k), bus4.err, 1);
        end
        check("sat err_count", bus.err_count, 17);
        check("sat cnt4 err_count", bus4.err_count, 15);
        check("sat bit_count", bus.bit_count, 310);

        // All-zero taps: counters cleared, stays IDLE.
        bus.load = 1'b1; bus.prog = 1'b0; bus.enable = 1'b1;
        tick();
        check("zero load err_count", bus.err_count, 0);
        check("zero load bit_count", bus.bit_count, 0);
        for (int i = 1; i < N; i++) tick();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(1'b0);
            seen = seen | bus.locked | bus.err;
        end
        check("zero taps locked/err seen", seen, 0);
        check("zero taps bit_count", bus.bit_count, 0);

        // Reload, lock, then reset while LOCKED with an inverted bit present.
        for (int i = 0; i < N; i++) begin
            bus.load = 1'b1; bus.prog = taps_v[i];
            tick();
        end
        gen_reg = SEED;
        for (int i = 0; i < 9; i++) send(1'b0);
        check("reload locked", bus.locked, 1);
        send(1'b1);
        check("pre-reset err_count", bus.err_count, 1);
        rst = 1'b1;
        send(1'b1);
        check("reset locked", bus.locked, 0);
        check("reset err", bus.err, 0);
        check("reset sync_loss", bus.sync_loss, 0);
        check("reset err_count", bus.err_count, 0);
        check("reset bit_count", bus.bit_count, 0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
